bean_port_ctrl: RTL and testbench



---
 rtl/bean_port_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bean_port_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bean_port_ctrl.sv
// bean_port_ctrl: sequencer/arbiter for port B of bean_ram.
// Shares the single write/check port between player eat requests (read-check-clear)
// and a full-grid refill, and tracks the number of beans remaining.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   eat_req/x/y       level eat request with player cell coordinates
//   eat_ack, eaten    eat finished pulse, bean cleared pulse
//   refill_req        request a full-grid refill (sampled in idle only)
//   refill_done       refill finished pulse
//   busy              controller not idle
//   bean_count        beans remaining
//   ram_en/we/addr/wdata, ram_rdata   bean_ram port B (read latency 1)
//
// Optional feature: define BEAN_LAST_CELL_FILTER_EN to skip the RAM check for an eat
// on the cell that last completed a check (cleared by reset and refill).
// All outputs are registered; there is no combinational path from inputs to outputs.

module bean_port_ctrl #(
  parameter int unsigned GRID_W     = 64,
  parameter int unsigned GRID_H     = 48,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned INIT_COUNT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eat_req,
  input  logic [5:0]        eat_x,
  input  logic [5:0]        eat_y,
  output logic              eat_ack,
  output logic              eaten,
  input  logic              refill_req,
  output logic              refill_done,
  output logic              busy,
  output logic [CNT_W-1:0]  bean_count,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic              ram_rdata
);

  localparam int unsigned NumCells = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    StIdle, StRd, StChk, StWr, StAck, StFill, StFdone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Coordinates widened to 32 bits so range checks work for any grid size.
  logic [31:0]       cell_x, cell_y;
  logic              in_range;
  logic [ADDR_W-1:0] eat_addr;
  logic              filt_hit;

  assign cell_x   = 32'(eat_x);
  assign cell_y   = 32'(eat_y);
  assign in_range = (cell_x < GRID_W) && (cell_y < GRID_H);
  assign eat_addr = ADDR_W'(cell_y * GRID_W + cell_x);

`ifdef BEAN_LAST_CELL_FILTER_EN
  logic              filt_vld_q, filt_vld_d;
  logic [ADDR_W-1:0] filt_addr_q, filt_addr_d;
  assign filt_hit = filt_vld_q && (filt_addr_q == eat_addr);
`else
  assign filt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    count_d = count_q;
`ifdef BEAN_LAST_CELL_FILTER_EN
    filt_vld_d  = filt_vld_q;
    filt_addr_d = filt_addr_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Refill wins over a simultaneous eat; a held eat is served afterwards.
        if (refill_req) begin
          state_d = StFill;
          fill_d  = '0;
`ifdef BEAN_LAST_CELL_FILTER_EN
          filt_vld_d = 1'b0;
`endif
        end else if (eat_req) begin
          if (!in_range || filt_hit) begin
            state_d = StAck;
          end else begin
            state_d = StRd;
            addr_d  = eat_addr;
          end
        end
      end
      StRd:  state_d = StChk;
      StChk: begin
        // ram_rdata holds the cell read during StRd.
        state_d = ram_rdata ? StWr : StAck;
`ifdef BEAN_LAST_CELL_FILTER_EN
        filt_vld_d  = 1'b1;
        filt_addr_d = addr_q;
`endif
      end
      StWr: begin
        state_d = StAck;
        if (count_q != '0) count_d = count_q - 1'b1;
      end
      StAck: state_d = StIdle;
      StFill: begin
        if (fill_q == ADDR_W'(NumCells - 1)) begin
          state_d = StFdone;
          count_d = CNT_W'(NumCells);
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      StFdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values and registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      fill_q      <= '0;
      count_q     <= CNT_W'(INIT_COUNT);
      eat_ack     <= 1'b0;
      eaten       <= 1'b0;
      refill_done <= 1'b0;
      busy        <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= 1'b0;
`ifdef BEAN_LAST_CELL_FILTER_EN
      filt_vld_q  <= 1'b0;
      filt_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      eat_ack     <= (state_d == StAck);
      eaten       <= (state_d == StWr);
      refill_done <= (state_d == StFdone);
      busy        <= (state_d != StIdle);
      ram_en      <= (state_d == StRd) || (state_d == StWr) || (state_d == StFill);
      ram_we      <= (state_d == StWr) || (state_d == StFill);
      ram_wdata   <= (state_d == StFill);
      if (state_d == StFill)                         ram_addr <= fill_d;
      else if (state_d == StRd || state_d == StWr)   ram_addr <= addr_d;
      else                                           ram_addr <= '0;
`ifdef BEAN_LAST_CELL_FILTER_EN
      filt_vld_q  <= filt_vld_d;
      filt_addr_q <= filt_addr_d;
`endif
    end
  end

  assign bean_count = count_q;

endmodule

// File: tb/tb_bean_port_ctrl.sv
// Directed testbench for bean_port_ctrl with a behavioural 3072x1 bean_ram (port B,
// read latency 1). The RAM model is filled with beans while rst is high.
`timescale 1ns/1ps

module tb_bean_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        eat_req, refill_req, ram_rdata;
  logic [5:0]  eat_x, eat_y;
  logic        eat_ack, eaten, refill_done, busy;
  logic [11:0] bean_count;
  logic        ram_en, ram_we, ram_wdata;
  logic [18:0] ram_addr;

  int total = 0;
  int bad   = 0;

  bean_port_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .eat_req    (eat_req),
    .eat_x      (eat_x),
    .eat_y      (eat_y),
    .eat_ack    (eat_ack),
    .eaten      (eaten),
    .refill_req (refill_req),
    .refill_done(refill_done),
    .busy       (busy),
    .bean_count (bean_count),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  logic mem [0:3071];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3072; i++) mem[i] <= 1'b1;
      ram_rdata <= 1'b0;
    end else if (ram_en && ram_addr < 19'd3072) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // kind: 0 = bean present, 1 = cell empty, 2 = immediate ack (out of range / filtered)
  task automatic run_eat(input logic [5:0] x, input logic [5:0] y, input int kind,
                         input int exp_addr, input int exp_cnt);
    eat_x = x; eat_y = y; eat_req = 1'b1;
    step();
    if (kind == 2) begin
      chk("short_ack", eat_ack, 1);
      chk("short_no_ram", ram_en, 0);
    end else begin
      chk("rd_en_we", {ram_en, ram_we}, 2'b10);
      chk("rd_addr", ram_addr, exp_addr);
      step();
      chk("chk_no_ram", ram_en, 0);
      chk("chk_no_ack", eat_ack, 0);
      step();
      if (kind == 0) begin
        chk("wr_en_we_wd_eaten", {ram_en, ram_we, ram_wdata, eaten}, 4'b1101);
        chk("wr_addr", ram_addr, exp_addr);
        chk("wr_no_ack", eat_ack, 0);
        step();
      end
      chk("ack", eat_ack, 1);
      chk("ack_no_ram", ram_en, 0);
    end
    chk("ack_no_eaten", eaten, 0);
    chk("count", bean_count, exp_cnt);
    eat_req = 1'b0;
    step();
    chk("back_idle", busy, 0);
  endtask

  // Caller may have eat_req already raised; refill must still go first.
  task automatic do_fill();
    int errs = 0;
    refill_req = 1'b1;
    step();
    refill_req = 1'b0;
    for (int i = 0; i < 3072; i++) begin
      if (!(ram_en && ram_we && ram_wdata && busy) || ram_addr != 19'(i) || refill_done)
        errs++;
      step();
    end
    chk("fill_writes", errs, 0);
    chk("refill_done", refill_done, 1);
    chk("fill_count", bean_count, 3072);
    chk("fdone_no_ram", ram_en, 0);
    step();
    chk("fill_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; eat_req = 1'b0; refill_req = 1'b0; eat_x = '0; eat_y = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_ram", {ram_en, ram_we, ram_wdata}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_pulses", {eat_ack, eaten, refill_done}, 0);
    chk("rst_count", bean_count, 0);
    rst = 1'b0;
    step();

    // Saturation: RAM preloaded with beans, count starts at 0.
    run_eat(6'd0, 6'd0, 0, 0, 0);

    do_fill();
    run_eat(6'd5, 6'd3, 0, 197, 3071);
`ifdef BEAN_LAST_CELL_FILTER_EN
    run_eat(6'd5, 6'd3, 2, 197, 3071);
`else
    run_eat(6'd5, 6'd3, 1, 197, 3071);
`endif

    // Out of range row.
    run_eat(6'd0, 6'd48, 2, 0, 3071);

    // Arbitration: both requests in one idle cycle.
    eat_x = 6'd10; eat_y = 6'd10; eat_req = 1'b1;
    do_fill();
    run_eat(6'd10, 6'd10, 0, 650, 3071);

`ifdef BEAN_LAST_CELL_FILTER_EN
    run_eat(6'd7, 6'd7, 0, 455, 3070);
    run_eat(6'd7, 6'd7, 2, 455, 3070);
    do_fill();
    run_eat(6'd7, 6'd7, 0, 455, 3071);
`endif

    // Reset in the middle of a refill.
    refill_req = 1'b1;
    step();
    refill_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("mid_fill_addr", ram_addr, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_count", bean_count, 0);
    chk("mid_rst_done", refill_done, 0);
    step();
    chk("mid_rst_still_idle", {busy, refill_done, ram_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
